// File: rtl/and3_bist_ctrl_if.sv
// Test-access and CUT-side signals of the AND3 BIST controller.
// master: test-access logic plus the CUT (drives start/abort and cut_o).
// slave : the BIST controller itself.
interface and3_bist_ctrl_if;
    localparam int unsigned SIG_W = 8;

    logic             start;
    logic             abort;
    logic             cut_i0;
    logic             cut_i1;
    logic             cut_i2;
    logic             cut_o;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;

    modport master (
        output start, abort, cut_o,
        input  cut_i0, cut_i1, cut_i2, busy, done, pass, sig
    );

    modport slave (
        input  start, abort, cut_o,
        output cut_i0, cut_i1, cut_i2, busy, done, pass, sig
    );
endinterface

// File: rtl/and3_bist_ctrl.sv
// BIST controller for a 3-input AND CUT: LFSR pattern source, SISR
// compaction of the CUT output and a final compare against GOLDEN.
module and3_bist_ctrl #(
    parameter logic [7:0]  SEED   = 8'h01,
    parameter int unsigned N_PAT  = 255,
    parameter logic [7:0]  GOLDEN = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    and3_bist_ctrl_if.slave bus
);
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned SIG_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CUT_W  = 3;

    // An all-zero seed would lock the LFSR, so it is replaced at load.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N_PAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q,  lfsr_d;
    logic [SIG_W-1:0]   sig_q,   sig_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               pass_q,  pass_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [CUT_W-1:0]   cut_q,   cut_d;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Serial-input signature register on the same polynomial.
    function automatic logic [SIG_W-1:0] sisr_step(input logic [SIG_W-1:0] v,
                                                    input logic           din);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3] ^ din};
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cut_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cut_q   <= cut_d;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cut_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                lfsr_d  = SEED_EFF;
                sig_d   = '0;
                cnt_d   = '0;
                pass_d  = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                sig_d  = sisr_step(sig_q, bus.cut_o);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                pass_d  = (sig_q == GOLDEN);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over any in-flight update; LFSR and signature freeze.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            lfsr_d  = lfsr_q;
            sig_d   = sig_q;
            cnt_d   = cnt_q;
            pass_d  = 1'b0;
        end

        // Outputs are decoded from the upcoming state so they are registered.
        busy_d = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_COMPARE);
        done_d = (state_d == S_DONE);
        if (state_d == S_RUN) begin
            cut_d = lfsr_d[CUT_W-1:0];
        end
    end

    assign bus.cut_i0 = cut_q[0];
    assign bus.cut_i1 = cut_q[1];
    assign bus.cut_i2 = cut_q[2];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.pass   = pass_q;
    assign bus.sig    = sig_q;

endmodule

// File: tb/tb_and3_bist_ctrl.sv
// Self-checking bench for and3_bist_ctrl: four instances with different
// SEED/N_PAT/GOLDEN, checked cycle by cycle against a run-timeline model.
module tb_and3_bist_ctrl;
    localparam int NDUT = 4;
    // Per instance g the byte [g*8 +: 8]: g0, g1, g2, g3.
    localparam logic [31:0] SEEDS = {8'hA5, 8'h00, 8'h01, 8'h07};
    localparam logic [31:0] NPATS = {8'd37, 8'd255, 8'd2, 8'd1};
    localparam logic [31:0] GOLDS = {8'h5A, 8'h00, 8'h00, 8'h01};

    logic clk = 1'b0;
    logic rst;
    logic [NDUT-1:0] start_v;
    logic [NDUT-1:0] abort_v;
    logic [NDUT-1:0] force0_v;

    wire [NDUT-1:0] busy_w;
    wire [NDUT-1:0] done_w;
    wire [NDUT-1:0] pass_w;
    wire [2:0]      cut_w [NDUT];
    wire [7:0]      sig_w [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    // Model results for the run currently being checked.
    int pat_m [256];
    int sig_m [256];
    int lfsr_m;
    int pass_m;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        and3_bist_ctrl_if bus ();
        and3_bist_ctrl #(
            .SEED  (SEEDS[g*8 +: 8]),
            .N_PAT (32'(NPATS[g*8 +: 8])),
            .GOLDEN(GOLDS[g*8 +: 8])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
        assign bus.start   = start_v[g];
        assign bus.abort   = abort_v[g];
        assign bus.cut_o   = force0_v[g] ? 1'b0 : (bus.cut_i0 & bus.cut_i1 & bus.cut_i2);
        assign busy_w[g]   = bus.busy;
        assign done_w[g]   = bus.done;
        assign pass_w[g]   = bus.pass;
        assign cut_w[g]    = {bus.cut_i2, bus.cut_i1, bus.cut_i0};
        assign sig_w[g]    = bus.sig;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int npat(input int g);
        return int'(NPATS[g*8 +: 8]);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Whole-run model: pattern list, signature after each pattern, verdict.
    task automatic build_model(input int g);
        int s, sg, n, co, fb;
        s  = int'(SEEDS[g*8 +: 8]);
        if (s == 0) s = 1;
        sg = 0;
        n  = npat(g);
        sig_m[0] = 0;
        for (int k = 0; k < n; k++) begin
            pat_m[k] = s % 8;
            co = (force0_v[g] == 1'b0 && pat_m[k] == 7) ? 1 : 0;
            fb = ((sg >> 7) ^ (sg >> 5) ^ (sg >> 4) ^ (sg >> 3) ^ co) & 1;
            sg = ((sg * 2) + fb) % 256;
            sig_m[k+1] = sg;
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = ((s * 2) + fb) % 256;
        end
        lfsr_m = s;
        pass_m = (sg == int'(GOLDS[g*8 +: 8])) ? 1 : 0;
    endtask

    // Expected {busy, done, cut[2:0]} in cycle c after the start edge.
    function automatic logic [4:0] exp_ctl(input int n, input int c);
        logic b, d;
        logic [2:0] p;
        b = (c >= 1 && c <= n + 2);
        d = (c == n + 3);
        p = (c >= 2 && c <= n + 1) ? 3'(pat_m[c-2]) : 3'd0;
        return {b, d, p};
    endfunction

    function automatic logic [4:0] obs_ctl(input int g);
        return {busy_w[g], done_w[g], cut_w[g]};
    endfunction

    task automatic check_reset_all(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_ctl%0d", tag, g), 32'(obs_ctl(g)), 32'd0);
            check($sformatf("%s_pass%0d", tag, g), 32'(pass_w[g]), 32'd0);
            check($sformatf("%s_sig%0d", tag, g), 32'(sig_w[g]), 32'd0);
        end
    endtask

    // Per-cycle checks shared by the run tasks (cycle c of the timeline).
    task automatic check_cycle(input int g, input int n, input int c, input string tag);
        check($sformatf("%s_ctl_c%0d", tag, c), 32'(obs_ctl(g)), 32'(exp_ctl(n, c)));
        if (c >= 2 && c <= n + 2)
            check($sformatf("%s_pass_c%0d", tag, c), 32'(pass_w[g]), 32'd0);
        else if (c >= n + 3)
            check($sformatf("%s_pass_c%0d", tag, c), 32'(pass_w[g]), 32'(pass_m));
        if (c >= 2)
            check($sformatf("%s_sig_c%0d", tag, c), 32'(sig_w[g]), 32'(sig_m[imin(c - 2, n)]));
    endtask

    // One start-pulse run; jitter toggles start while busy, both raises abort with start.
    task automatic run_check(input int g, input bit jitter, input bit both);
        int n, busy_len;
        n = npat(g);
        build_model(g);
        busy_len = 0;
        start_v[g] = 1'b1;
        abort_v[g] = both;
        for (int c = 1; c <= n + 5; c++) begin
            @(negedge clk);
            check_cycle(g, n, c, $sformatf("run%0d", g));
            if (busy_w[g]) busy_len++;
            abort_v[g] = 1'b0;
            start_v[g] = (jitter && c <= n + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        check($sformatf("busy_len%0d", g), 32'(busy_len), 32'(n + 2));
    endtask

    // Start pulse, abort sampled at the end of cycle a (2 <= a <= n+3).
    task automatic run_abort(input int g, input int a);
        int n;
        n = npat(g);
        build_model(g);
        start_v[g] = 1'b1;
        for (int c = 1; c <= a + 3; c++) begin
            @(negedge clk);
            if (c <= a) begin
                check_cycle(g, n, c, $sformatf("abt%0d", g));
            end else begin
                check($sformatf("abt%0d_ctl_c%0d", g, c), 32'(obs_ctl(g)), 32'd0);
                check($sformatf("abt%0d_pass_c%0d", g, c), 32'(pass_w[g]), 32'd0);
                check($sformatf("abt%0d_sig_c%0d", g, c), 32'(sig_w[g]),
                      32'(sig_m[imin(a - 2, n)]));
            end
            start_v[g] = 1'b0;
            abort_v[g] = (c == a);
        end
    endtask

    // start held high: runs repeat every n+4 cycles (one IDLE between DONE and INIT).
    task automatic run_hold(input int g, input int runs);
        int n, cc;
        n = npat(g);
        build_model(g);
        start_v[g] = 1'b1;
        for (int c = 1; c <= runs * (n + 4); c++) begin
            @(negedge clk);
            cc = ((c - 1) % (n + 4)) + 1;
            check($sformatf("hold_ctl_c%0d", c), 32'(obs_ctl(g)), 32'(exp_ctl(n, cc)));
            if (cc >= 2 && cc <= n + 2)
                check($sformatf("hold_pass_c%0d", c), 32'(pass_w[g]), 32'd0);
            else if (cc >= n + 3)
                check($sformatf("hold_pass_c%0d", c), 32'(pass_w[g]), 32'(pass_m));
            if (c == runs * (n + 4) - 1) start_v[g] = 1'b0;
        end
    endtask

    // Asynchronous reset in RUN cycle rc; outputs must clear before the next edge.
    task automatic run_reset(input int g, input int rc);
        int n;
        n = npat(g);
        build_model(g);
        start_v[g] = 1'b1;
        for (int c = 1; c <= rc; c++) begin
            @(negedge clk);
            check_cycle(g, n, c, "rstrun");
            start_v[g] = 1'b0;
        end
        #2 rst = 1'b1;
        #1 check_reset_all("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_all("rst_after");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start_v  = '0;
        abort_v  = '0;
        force0_v = '0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_all("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_all("reset_rel");

        // SEED 07, one pattern, real CUT.
        run_check(0, 1'b0, 1'b0);
        check("tp1_sig", 32'(sig_w[0]), 32'h01);
        check("tp1_pass", 32'(pass_w[0]), 32'd1);

        // abort alone in IDLE changes nothing.
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        @(negedge clk);
        check("idle_abort_ctl", 32'(obs_ctl(0)), 32'd0);
        check("idle_abort_pass", 32'(pass_w[0]), 32'd1);
        check("idle_abort_sig", 32'(sig_w[0]), 32'h01);

        // Same run with the CUT output stuck at 0.
        force0_v[0] = 1'b1;
        run_check(0, 1'b0, 1'b0);
        check("tp2_sig", 32'(sig_w[0]), 32'h00);
        check("tp2_pass", 32'(pass_w[0]), 32'd0);
        force0_v[0] = 1'b0;

        // SEED 01, two patterns.
        run_check(1, 1'b0, 1'b0);
        check("tp3_lfsr", 32'(g_dut[1].u_dut.lfsr_q), 32'h04);
        check("tp3_sig", 32'(sig_w[1]), 32'h00);
        check("tp3_pass", 32'(pass_w[1]), 32'd1);

        // start and abort together in IDLE still starts a run.
        run_check(1, 1'b0, 1'b1);

        // SEED 00, 255 patterns: abort in the 100th RUN cycle, then a clean run.
        run_abort(2, 101);
        run_check(2, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a run.
        run_reset(2, 50);

        // Back-to-back runs with start held.
        run_hold(1, 3);

        // Randomised runs and aborts on the SEED A5 / 37-pattern instance.
        for (int it = 0; it < 10; it++) begin
            force0_v[3] = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 1)
                run_check(3, 1'b1, 1'($urandom_range(0, 1)));
            else
                run_abort(3, int'($urandom_range(2, 40)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/and3_bist_ctrl.md
# and3_bist_ctrl

Built-in self-test controller for the 3-input AND cut-under-test. On a start request it:
- seeds an 8-bit LFSR;
- drives N_PAT pseudo-random patterns onto the CUT inputs;
- compacts the single CUT output into an 8-bit serial signature register (SISR);
- compares the final signature against a golden value.

It sits between the test-access logic (start/abort/status) and the combinational CUT, which it sequences exclusively while busy.

## Interface
- SEED, 8'h01, LFSR seed; a value of 8'h00 is replaced by 8'h01 at load.
- N_PAT, 255, patterns per run; range 1..255.
- GOLDEN, 8'h00, expected final signature.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level request; sampled only in IDLE.
- abort  input  1  synchronous; returns to IDLE from any non-IDLE state.
- cut_i0  output  1  CUT input 0 = lfsr[0] during RUN, else 0.
- cut_i1  output  1  CUT input 1 = lfsr[1] during RUN, else 0.
- cut_i2  output  1  CUT input 2 = lfsr[2] during RUN, else 0.
- cut_o  input  1  CUT output, combinational from cut_i*.
- busy  output  1  high in INIT, RUN, COMPARE.
- done  output  1  one-cycle pulse in DONE.
- pass  output  1  result of last completed run; held until next INIT or abort.
- sig  output  8  current SISR contents.

## Operation
- Reset: state IDLE, lfsr=8'h00, sig=8'h00, cnt=0, busy=0, done=0, pass=0, cut_i*=0.
- States and transitions:
  - IDLE: start=1 goes to INIT; otherwise stay.
  - INIT (1 cycle): lfsr←SEED (or 8'h01 if SEED=0), sig←0, cnt←0, pass←0; then RUN.
  - RUN: each cycle cut_i* = lfsr[2:0] and sig samples cut_o; lfsr and sig advance; cnt++. Leave for COMPARE on the cycle where cnt==N_PAT-1.
  - COMPARE (1 cycle): pass←(sig==GOLDEN); then DONE.
  - DONE (1 cycle): done=1; then IDLE.
- LFSR step (Fibonacci, x^8+x^6+x^5+x^4+1): lfsr←{lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- SISR step: sig←{sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]^cut_o}.
- cnt: 8-bit; never wraps, because exit occurs at N_PAT-1 ≤ 254.
- sig and lfsr hold their values outside INIT and RUN, so sig remains readable after done.
- start is ignored outside IDLE. If start is still high in the cycle after DONE, a new run begins immediately.
- abort in INIT/RUN/COMPARE/DONE:
  - next state IDLE, pass←0, done stays 0, cut_i*←0;
  - lfsr and sig hold their values.
- abort in IDLE has no effect. If abort and start are both high in IDLE, the run starts.
- rst mid-run: immediate return to the reset values above, with no done pulse.

## Timing
- Let the start-sampling edge be edge 0. Then:
  - INIT occupies cycle 1;
  - RUN occupies cycles 2..N_PAT+1;
  - COMPARE occupies cycle N_PAT+2;
  - DONE (done=1) occupies cycle N_PAT+3.
- busy is high in cycles 1..N_PAT+2.
- cut_i* change only on clk edges. Pattern k (k=0..N_PAT-1) is applied in cycle k+2 and its cut_o is captured at the end of that cycle.
- pass is valid from cycle N_PAT+3 (coincident with done) onward.
- Outputs are registered or direct decodes of state; there is no combinational path from start or abort to any output.

## Test plan
- SEED=8'h07, N_PAT=1, GOLDEN=8'h01, real CUT, pulse start:
  - required: cut_i*=111 for one cycle, sig=8'h01, done pulses 4 cycles after the start edge, pass=1.
- Same configuration with cut_o forced to 0:
  - required: sig=8'h00, done pulses, pass=0.
- SEED=8'h01, N_PAT=2, GOLDEN=8'h00:
  - required: cut_i* sequence {i2,i1,i0} = 001 then 010, lfsr ends at 8'h04, sig=8'h00, pass=1, busy high for exactly 4 cycles.
- SEED=8'h00:
  - required: the first applied pattern is {i2,i1,i0}=001 (loaded seed 8'h01).
- N_PAT=255 run, with abort asserted in the 100th RUN cycle:
  - required: next cycle IDLE, busy=0, cut_i*=0, pass=0, no done pulse.
  - A subsequent start must complete normally with done at edge 258 relative to its start edge.
- rst asserted asynchronously mid-RUN:
  - required: all outputs at reset values before the next clk edge.
- start held high continuously:
  - required: back-to-back runs with exactly one IDLE cycle between DONE and INIT.
  - start pulses during busy are ignored.
